// File: rtl/homography_pkg.sv
// rtl/homography_pkg.sv - shared types and constants for the homography responder
package homography_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_MAC,
      S_DIVX,
      S_DIVY,
      S_MEM,
      S_DONE
   } state_e;

   localparam int H_RES_DEF = 640;
   localparam int V_RES_DEF = 480;
   localparam int FRAC_DEF  = 10;

   localparam logic [2:0] C_H00 = 3'd0;
   localparam logic [2:0] C_H01 = 3'd1;
   localparam logic [2:0] C_H02 = 3'd2;
   localparam logic [2:0] C_H10 = 3'd3;
   localparam logic [2:0] C_H11 = 3'd4;
   localparam logic [2:0] C_H12 = 3'd5;
   localparam logic [2:0] C_H20 = 3'd6;
   localparam logic [2:0] C_H21 = 3'd7;

   localparam int R_MSB = 15;
   localparam int R_LSB = 11;
   localparam int G_MSB = 10;
   localparam int G_LSB = 5;
   localparam int B_MSB = 4;
   localparam int B_LSB = 0;

   function automatic logic in_bounds(input logic signed [31:0] v, input int lim);
      return (v >= 0) && (v < lim);
   endfunction

endpackage

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - 32-bit signed restoring divider, fixed 32-cycle latency
// Divides magnitudes, then negates when operand signs differ (truncation toward zero).
module seq_divider (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               go_i,
   input  logic signed [31:0] dividend_i,
   input  logic signed [31:0] divisor_i,
   output logic               done_o,
   output logic signed [31:0] quotient_o
);

   logic        busy_q;
   logic [4:0]  cnt_q;
   logic [31:0] rem_q;
   logic [31:0] quo_q;
   logic [31:0] dsr_q;
   logic        neg_q;

   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [31:0] shifted;
   logic        fits;
   logic [31:0] rem_step;
   logic [31:0] quo_step;

   always_comb begin
      a_mag    = dividend_i[31] ? -dividend_i : dividend_i;
      b_mag    = divisor_i[31]  ? -divisor_i  : divisor_i;
      shifted  = {rem_q[30:0], quo_q[31]};
      // a set rem_q[31] means the shifted remainder exceeds 32 bits, so it always fits
      fits     = rem_q[31] | (shifted >= dsr_q);
      rem_step = fits ? (shifted - dsr_q) : shifted;
      quo_step = {quo_q[30:0], fits};
   end

   assign done_o     = busy_q && (cnt_q == 5'd31);
   assign quotient_o = neg_q ? -quo_step : quo_step;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
         rem_q  <= '0;
         quo_q  <= '0;
         dsr_q  <= '0;
         neg_q  <= 1'b0;
      end else if (go_i) begin
         busy_q <= 1'b1;
         cnt_q  <= '0;
         rem_q  <= '0;
         quo_q  <= a_mag;
         dsr_q  <= b_mag;
         neg_q  <= dividend_i[31] ^ divisor_i[31];
      end else if (busy_q) begin
         rem_q <= rem_step;
         quo_q <= quo_step;
         cnt_q <= cnt_q + 5'd1;
         if (cnt_q == 5'd31) begin
            busy_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/homography_responder.sv
// rtl/homography_responder.sv - maps a display query through a 3x3 projective matrix
// and returns the RGB565 source pixel fetched from the frame buffer.
module homography_responder
   import homography_pkg::*;
#(
   parameter int H_RES = H_RES_DEF,
   parameter int V_RES = V_RES_DEF,
   parameter int FRAC  = FRAC_DEF,
   parameter int CW    = 18
) (
   input  logic                 clk_25,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [9:0]           query_x,
   input  logic [9:0]           query_y,
   output logic                 ready,
   output logic [9:0]           return_x,
   output logic [9:0]           return_y,
   output logic [4:0]           r,
   output logic [5:0]           g,
   output logic [4:0]           b,
   input  logic                 coef_we,
   input  logic [2:0]           coef_addr,
   input  logic signed [CW-1:0] coef_data,
   output logic                 mem_req,
   output logic [18:0]          mem_addr,
   input  logic                 mem_ack,
   input  logic [15:0]          mem_data,
   output logic                 busy,
   output logic                 overrun
);

   localparam int ONE = 1 << FRAC;

   function automatic logic signed [31:0] sext(input logic signed [CW-1:0] c);
      return {{(32-CW){c[CW-1]}}, c};
   endfunction

   state_e state_q, state_d;
   logic signed [CW-1:0] coef_q [8];
   logic [9:0]          qx_q, qx_d, qy_q, qy_d;
   logic signed [31:0]  ny_q, ny_d, den_q, den_d, sx_q, sx_d;
   logic [18:0]         mem_addr_q, mem_addr_d;
   logic                mem_req_q, mem_req_d, ready_q, ready_d;
   logic                busy_q, busy_d, overrun_q, overrun_d;
   logic [9:0]          rx_q, rx_d, ry_q, ry_d;
   logic [15:0]         rgb_q, rgb_d, pix_d;

   logic signed [31:0]  xs, ys, mac_nx, mac_ny, mac_den;
   logic                div_go, div_done;
   logic signed [31:0]  div_a, div_b, div_q;

   always_comb begin
      xs      = {22'd0, qx_q};
      ys      = {22'd0, qy_q};
      mac_nx  = sext(coef_q[C_H00]) * xs + sext(coef_q[C_H01]) * ys + sext(coef_q[C_H02]);
      mac_ny  = sext(coef_q[C_H10]) * xs + sext(coef_q[C_H11]) * ys + sext(coef_q[C_H12]);
      mac_den = sext(coef_q[C_H20]) * xs + sext(coef_q[C_H21]) * ys + ONE;
   end

   // x division is launched straight from the MAC result; y launches on x's final iteration
   assign div_go = ((state_q == S_MAC) && (mac_den > 0)) || ((state_q == S_DIVX) && div_done);
   assign div_a  = (state_q == S_MAC) ? mac_nx  : ny_q;
   assign div_b  = (state_q == S_MAC) ? mac_den : den_q;

   seq_divider u_div (
      .clk_i      (clk_25),
      .rst_ni     (rst_n),
      .go_i       (div_go),
      .dividend_i (div_a),
      .divisor_i  (div_b),
      .done_o     (div_done),
      .quotient_o (div_q)
   );

   always_comb begin
      state_d    = state_q;
      qx_d       = qx_q;
      qy_d       = qy_q;
      ny_d       = ny_q;
      den_d      = den_q;
      sx_d       = sx_q;
      mem_addr_d = mem_addr_q;
      rx_d       = rx_q;
      ry_d       = ry_q;
      rgb_d      = rgb_q;
      pix_d      = '0;
      unique case (state_q)
         S_IDLE: if (start) begin
            qx_d    = query_x;
            qy_d    = query_y;
            state_d = S_MAC;
         end
         S_MAC: begin
            ny_d    = mac_ny;
            den_d   = mac_den;
            state_d = (mac_den > 0) ? S_DIVX : S_DONE;
         end
         S_DIVX: if (div_done) begin
            sx_d    = div_q;
            state_d = S_DIVY;
         end
         S_DIVY: if (div_done) begin
            if (in_bounds(sx_q, H_RES) && in_bounds(div_q, V_RES)) begin
               mem_addr_d = 19'(div_q * H_RES + sx_q);
               state_d    = S_MEM;
            end else begin
               state_d = S_DONE;
            end
         end
         S_MEM: if (mem_ack) begin
            pix_d   = mem_data;
            state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // result registers only change on entry to S_DONE and hold until the next one
      if (state_d == S_DONE) begin
         rx_d  = qx_q;
         ry_d  = qy_q;
         rgb_d = pix_d;
      end
      ready_d   = (state_d == S_DONE);
      busy_d    = (state_d != S_IDLE);
      mem_req_d = (state_d == S_MEM);
      overrun_d = overrun_q | (start && (state_q != S_IDLE));
   end

   always_ff @(posedge clk_25 or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         qx_q       <= '0;
         qy_q       <= '0;
         ny_q       <= '0;
         den_q      <= '0;
         sx_q       <= '0;
         mem_addr_q <= '0;
         mem_req_q  <= 1'b0;
         ready_q    <= 1'b0;
         busy_q     <= 1'b0;
         overrun_q  <= 1'b0;
         rx_q       <= '0;
         ry_q       <= '0;
         rgb_q      <= '0;
         for (int i = 0; i < 8; i++) begin
            coef_q[i] <= '0;
         end
         coef_q[C_H00] <= CW'(ONE);
         coef_q[C_H11] <= CW'(ONE);
      end else begin
         state_q    <= state_d;
         qx_q       <= qx_d;
         qy_q       <= qy_d;
         ny_q       <= ny_d;
         den_q      <= den_d;
         sx_q       <= sx_d;
         mem_addr_q <= mem_addr_d;
         mem_req_q  <= mem_req_d;
         ready_q    <= ready_d;
         busy_q     <= busy_d;
         overrun_q  <= overrun_d;
         rx_q       <= rx_d;
         ry_q       <= ry_d;
         rgb_q      <= rgb_d;
         if (coef_we) begin
            coef_q[coef_addr] <= coef_data;
         end
      end
   end

   assign ready    = ready_q;
   assign busy     = busy_q;
   assign overrun  = overrun_q;
   assign mem_req  = mem_req_q;
   assign mem_addr = mem_addr_q;
   assign return_x = rx_q;
   assign return_y = ry_q;
   assign r        = rgb_q[R_MSB:R_LSB];
   assign g        = rgb_q[G_MSB:G_LSB];
   assign b        = rgb_q[B_MSB:B_LSB];

endmodule

// File: tb/tb_homography_responder.sv
// tb/tb_homography_responder.sv - directed scoreboard bench for homography_responder
module tb_homography_responder;

   localparam int H    = 640;
   localparam int V    = 480;
   localparam int FR   = 10;
   localparam int CWID = 24;

   logic            clk_25 = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic [9:0]      query_x = '0, query_y = '0;
   logic            ready;
   logic [9:0]      return_x, return_y;
   logic [4:0]      r, b;
   logic [5:0]      g;
   logic            coef_we = 1'b0;
   logic [2:0]      coef_addr = '0;
   logic [CWID-1:0] coef_data = '0;
   logic            mem_req;
   logic [18:0]     mem_addr;
   logic            mem_ack = 1'b0;
   logic [15:0]     mem_data = '0;
   logic            busy, overrun;

   homography_responder #(.H_RES(H), .V_RES(V), .FRAC(FR), .CW(CWID)) dut (
      .clk_25(clk_25), .rst_n(rst_n), .start(start), .query_x(query_x), .query_y(query_y),
      .ready(ready), .return_x(return_x), .return_y(return_y), .r(r), .g(g), .b(b),
      .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
      .busy(busy), .overrun(overrun)
   );

   always #20 clk_25 = ~clk_25;

   typedef struct {
      int          lat;
      logic        hit;
      logic [18:0] addr;
      logic [9:0]  rx;
      logic [9:0]  ry;
      logic [15:0] pix;
   } exp_t;

   exp_t sb[$];
   int   cm[8];
   int   vectors = 0;
   int   miscompares = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic set_identity();
      cm = '{1 << FR, 0, 0, 0, 1 << FR, 0, 0, 0};
   endtask

   task automatic write_coef(input int idx, input int val);
      @(posedge clk_25); #1;
      coef_we   = 1'b1;
      coef_addr = idx[2:0];
      coef_data = val[CWID-1:0];
      @(posedge clk_25); #1;
      coef_we = 1'b0;
      cm[idx] = val;
   endtask

   task automatic run_query(input int x, input int y, input int k, input logic [15:0] pix);
      exp_t   e, got;
      longint nx, ny, den, sx, sy;
      bit     done, req_seen;
      int     req_n;
      nx  = longint'(cm[0]) * x + longint'(cm[1]) * y + cm[2];
      ny  = longint'(cm[3]) * x + longint'(cm[4]) * y + cm[5];
      den = longint'(cm[6]) * x + longint'(cm[7]) * y + (1 << FR);
      e.rx = x[9:0]; e.ry = y[9:0]; e.hit = 1'b0; e.addr = '0; e.pix = '0;
      if (den <= 0) begin
         e.lat = 2;
      end else begin
         sx = nx / den;
         sy = ny / den;
         if (sx >= 0 && sx < H && sy >= 0 && sy < V) begin
            e.hit  = 1'b1;
            e.addr = 19'(sy * H + sx);
            e.pix  = pix;
            e.lat  = 67 + k;
         end else begin
            e.lat = 66;
         end
      end
      sb.push_back(e);

      @(posedge clk_25); #1;
      start = 1'b1; query_x = x[9:0]; query_y = y[9:0];
      @(posedge clk_25); #1;
      start = 1'b0;
      done = 1'b0; req_seen = 1'b0; req_n = 0;
      for (int n = 1; n <= 400 && !done; n++) begin
         if (n > 1) begin
            @(posedge clk_25); #1;
         end
         mem_ack = 1'b0;
         if (mem_req && !req_seen) begin
            req_seen = 1'b1;
            req_n    = n;
            check("req_cycle", n, 66);
            check("mem_addr", mem_addr, e.addr);
         end
         if (req_seen && mem_req && n == req_n + k) begin
            mem_ack  = 1'b1;
            mem_data = pix;
         end
         if (ready) begin
            got = sb.pop_front();
            check("ready_cycle", n, got.lat);
            check("return_x", return_x, got.rx);
            check("return_y", return_y, got.ry);
            check("rgb", {r, g, b}, got.pix);
            check("mem_req_seen", req_seen, got.hit);
            done = 1'b1;
         end
      end
      mem_ack = 1'b0;
      if (!done) begin
         check("ready_timeout", 0, 1);
         got = sb.pop_front();
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      set_identity();
      repeat (3) @(posedge clk_25);
      #1;
      check("rst_ready", ready, 0);
      check("rst_busy", busy, 0);
      check("rst_mem_req", mem_req, 0);
      check("rst_overrun", overrun, 0);
      check("rst_rgb_ret", {r, g, b, return_x, return_y}, 0);
      rst_n = 1'b1;

      run_query(100, 50, 0, 16'hF800);
      write_coef(2, 10 << FR);
      run_query(100, 50, 3, 16'h07E0);
      run_query(635, 0, 0, 16'hFFFF);
      write_coef(2, 0);
      write_coef(6, -4);
      run_query(300, 0, 0, 16'hFFFF);
      write_coef(6, 0);
      write_coef(0, -(1 << FR));
      write_coef(2, 639 << FR);
      run_query(0, 0, 1, 16'h001F);
      run_query(5, 0, 2, 16'h5A5A);
      write_coef(2, 0);
      run_query(5, 0, 0, 16'hFFFF);
      write_coef(0, -(1 << (FR - 1)));
      run_query(1, 3, 4, 16'hA5C3);

      write_coef(0, 1 << FR);
      write_coef(5, 5 << FR);
      @(posedge clk_25); #1;
      start = 1'b1; query_x = 10'd100; query_y = 10'd50;
      @(posedge clk_25); #1;
      start = 1'b0;
      for (int n = 1; n <= 68; n++) begin
         if (n > 1) begin
            @(posedge clk_25); #1;
         end
         start = (n == 10);
         if (n == 12) begin
            check("overrun_set", overrun, 1);
            check("busy_divx", busy, 1);
         end
         if (n == 66) begin
            check("ovr_mem_req", mem_req, 1);
            check("ovr_mem_addr", mem_addr, 55 * H + 100);
         end
         if (ready) check("ovr_no_ready", ready, 0);
      end
      rst_n = 1'b0;
      #1;
      check("mid_rst_mem_req", mem_req, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_overrun", overrun, 0);
      check("mid_rst_ready", ready, 0);
      check("mid_rst_rgb", {r, g, b}, 0);
      @(posedge clk_25); #1;
      rst_n = 1'b1;
      set_identity();
      repeat (3) @(posedge clk_25);
      #1;
      check("post_rst_ready", ready, 0);
      check("post_rst_busy", busy, 0);

      run_query(20, 30, 2, 16'h1234);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
